// File: rtl/spi_reg_bank_pkg.sv
// Shared types and default sizing for the SPI register bank.
`timescale 1ns/1ps
package spi_reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } spi_state_e;

  localparam int N_REGS_DEF = 5;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/spi_reg_bank_sync.sv
// Two-flop synchroniser for an asynchronous pin, followed by a one-flop edge detector.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_r;
  logic       prev_r;

  // synchroniser chain plus previous-level flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {2{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[0], din};
      prev_r <= sync_r[1];
    end
  end

  assign level = sync_r[1];
  assign rise  = sync_r[1] & ~prev_r;
  assign fall  = ~sync_r[1] & prev_r;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target with a bank of N_REGS writable/readable control registers.
`timescale 1ns/1ps
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclk,
  input  logic                     copi,
  input  logic                     ncs,
  output logic                     cipo,
  output logic                     cipo_oe,
  output logic [N_REGS*DATA_W-1:0] reg_q,
  output logic [N_REGS-1:0]        wr_pulse,
  output logic                     frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int SH_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [CNT_W-1:0]  CNT_CMD_END = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_FRAME   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT     = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT  = (ADDR_W+1)'(N_REGS);

  logic sclk_lvl_unused_s, sclk_rise_s, sclk_fall_s;
  logic ncs_lvl_unused_s, ncs_rise_s, ncs_fall_s;
  logic copi_lvl_s, copi_rise_unused_s, copi_fall_unused_s;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_lvl_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(ncs),
    .level(ncs_lvl_unused_s), .rise(ncs_rise_s), .fall(ncs_fall_s)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(copi),
    .level(copi_lvl_s), .rise(copi_rise_unused_s), .fall(copi_fall_unused_s)
  );

  spi_state_e        state_r, state_nx_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [SH_W-1:0]   shift_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] shadow_r;
  logic              overrun_r;
  logic              cipo_r, cipo_oe_r, frame_err_r;

  logic [ADDR_W:0]   cmd_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              frame_end_s, good_len_s, addr_ok_s, commit_s, err_s, shift_en_s;

  // command word completes with the bit arriving on this sclk rise
  assign cmd_s       = {shift_r[ADDR_W-1:0], copi_lvl_s};
  assign frame_end_s = ncs_rise_s && (state_r != ST_IDLE);
  assign good_len_s  = (bit_cnt_r == CNT_FRAME) && !overrun_r;
  assign addr_ok_s   = {1'b0, addr_r} < ADDR_LIMIT;
  assign commit_s    = frame_end_s && (state_r == ST_WDATA) && good_len_s && addr_ok_s;
  assign err_s       = frame_end_s && !commit_s && !((state_r == ST_RDATA) && good_len_s);
  // an sclk rise coinciding with ncs rise is dropped
  assign shift_en_s  = sclk_rise_s && !ncs_rise_s && (state_r != ST_IDLE);

  // read mux over the register bank; out-of-range addresses read as zero
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < N_REGS; i++) begin
      rd_data_s = rd_data_s |
                  (reg_q[i*DATA_W +: DATA_W] & {DATA_W{cmd_s[ADDR_W-1:0] == ADDR_W'(i)}});
    end
  end

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ncs_fall_s) state_nx_s = ST_CMD;
        else            state_nx_s = ST_IDLE;
      end
      ST_CMD: begin
        if (ncs_rise_s)                                      state_nx_s = ST_IDLE;
        else if (sclk_rise_s && (bit_cnt_r == CNT_CMD_END)) state_nx_s = cmd_s[ADDR_W] ? ST_WDATA : ST_RDATA;
        else                                                 state_nx_s = ST_CMD;
      end
      ST_WDATA, ST_RDATA: begin
        if (ncs_rise_s) state_nx_s = ST_IDLE;
        else            state_nx_s = state_r;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // frame datapath: bit counter, shift register, address latch, read shadow, cipo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      addr_r      <= '0;
      shadow_r    <= '0;
      overrun_r   <= 1'b0;
      cipo_r      <= 1'b0;
      cipo_oe_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= err_s;
      cipo_oe_r   <= (state_nx_s != ST_IDLE);
      if ((state_r == ST_IDLE) && ncs_fall_s) begin
        bit_cnt_r <= '0;
        shift_r   <= '0;
        overrun_r <= 1'b0;
      end else if (shift_en_s) begin
        if (bit_cnt_r != CNT_SAT) bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        if ((state_r == ST_CMD) || ((state_r == ST_WDATA) && (bit_cnt_r < CNT_FRAME)))
          shift_r <= {shift_r[SH_W-2:0], copi_lvl_s};
        if ((state_r == ST_WDATA) && (bit_cnt_r >= CNT_FRAME)) overrun_r <= 1'b1;
        if ((state_r == ST_CMD) && (bit_cnt_r == CNT_CMD_END)) begin
          addr_r   <= cmd_s[ADDR_W-1:0];
          shadow_r <= rd_data_s;
        end
      end
      // shadow shifts in zeros so bits past the data field read as 0
      if (state_nx_s != ST_RDATA) begin
        cipo_r <= 1'b0;
      end else if ((state_r == ST_RDATA) && sclk_fall_s) begin
        cipo_r   <= shadow_r[DATA_W-1];
        shadow_r <= {shadow_r[DATA_W-2:0], 1'b0};
      end
    end
  end

  genvar g;
  for (g = 0; g < N_REGS; g++) begin : g_reg
    logic [DATA_W-1:0] data_r;
    logic              pulse_r;

    // register g: written on the commit cycle of a good frame addressed to it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_r  <= '0;
        pulse_r <= 1'b0;
      end else begin
        pulse_r <= commit_s && (addr_r == ADDR_W'(g));
        if (commit_s && (addr_r == ADDR_W'(g))) data_r <= shift_r[DATA_W-1:0];
      end
    end

    assign reg_q[g*DATA_W +: DATA_W] = data_r;
    assign wr_pulse[g]               = pulse_r;
  end

  assign cipo      = cipo_r;
  assign cipo_oe   = cipo_oe_r;
  assign frame_err = frame_err_r;

endmodule
